// File: rtl/ram_loader_if.sv
// ram_loader_if: UART byte input and RAM write port of the program loader.
interface ram_loader_if #(
    parameter int MEM_WIDTH = 16,
    parameter int MEM_DEPTH = 256
);
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  w_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [MEM_WIDTH-1:0]  w_data;
    logic                  busy;
    logic                  cpu_hold;
    logic                  done;
    logic                  err;
    modport master (
        output rx_data, rx_valid,
        input  w_en, w_addr, w_data, busy, cpu_hold, done, err
    );
    modport slave (
        input  rx_data, rx_valid,
        output w_en, w_addr, w_data, busy, cpu_hold, done, err
    );
endinterface

// File: rtl/ram_loader.sv
// ram_loader: parses SYNC/ADDR/COUNT/DATA/CSUM byte frames into big-endian RAM word writes.
module ram_loader #(
    parameter int         MEM_WIDTH      = 16,
    parameter int         MEM_DEPTH      = 256,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input logic         clk,
    input logic         rst,
    ram_loader_if.slave bus
);
    localparam int BPW        = MEM_WIDTH / 8;
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
    localparam int TW         = $clog2(TIMEOUT_CYCLES);
    localparam int BW         = $clog2(BPW + 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_COUNT = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_CSUM  = 3'd4;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [8:0]            words;
    logic [BW-1:0]         idx;
    logic [7:0]            sum;
    logic [MEM_WIDTH-1:0]  word_q;
    logic [TW-1:0]         tmo;
    logic [MEM_WIDTH-1:0]  new_word;
    logic                  timeout;

    // Truncating the concatenation keeps the newest BPW bytes, MSB byte first.
    assign new_word     = MEM_WIDTH'({word_q, bus.rx_data});
    assign timeout      = state != S_IDLE && !bus.rx_valid && tmo == TW'(TIMEOUT_CYCLES - 1);
    assign bus.busy     = state != S_IDLE;
    assign bus.cpu_hold = bus.busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            words      <= '0;
            idx        <= '0;
            sum        <= '0;
            word_q     <= '0;
            tmo        <= '0;
            bus.w_en   <= 1'b0;
            bus.w_addr <= '0;
            bus.w_data <= '0;
            bus.done   <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            bus.w_en <= 1'b0;
            bus.done <= 1'b0;
            tmo      <= (state == S_IDLE || bus.rx_valid) ? '0 : tmo + 1'b1;
            if (bus.rx_valid) begin
                case (state)
                    S_IDLE: if (bus.rx_data == SYNC_BYTE) begin
                        state   <= S_ADDR;
                        bus.err <= 1'b0;
                    end
                    S_ADDR: begin
                        ptr   <= bus.rx_data[ADDR_WIDTH-1:0];
                        state <= S_COUNT;
                    end
                    S_COUNT: begin
                        // A count byte of zero means 256 words.
                        words <= {bus.rx_data == 8'd0, bus.rx_data};
                        sum   <= '0;
                        idx   <= '0;
                        state <= S_DATA;
                    end
                    S_DATA: begin
                        sum    <= sum + bus.rx_data;
                        word_q <= new_word;
                        if (idx == BW'(BPW - 1)) begin
                            bus.w_en   <= 1'b1;
                            bus.w_addr <= ptr;
                            bus.w_data <= new_word;
                            ptr        <= ptr + 1'b1;
                            words      <= words - 1'b1;
                            idx        <= '0;
                            if (words == 9'd1) state <= S_CSUM;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    S_CSUM: begin
                        bus.err  <= bus.rx_data != sum;
                        bus.done <= 1'b1;
                        state    <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (timeout) begin
                // A partially assembled word is simply dropped.
                bus.err  <= 1'b1;
                bus.done <= 1'b1;
                state    <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed frames against a frame-position model of the loader.
module tb_ram_loader;
    localparam int MEM_WIDTH = 16;
    localparam int MEM_DEPTH = 256;
    localparam int BPW       = MEM_WIDTH / 8;
    localparam int TMO       = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ram_loader_if #(.MEM_WIDTH(MEM_WIDTH), .MEM_DEPTH(MEM_DEPTH)) bus ();
    ram_loader #(.MEM_WIDTH(MEM_WIDTH), .MEM_DEPTH(MEM_DEPTH), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO))
        dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Model: tracks position inside the frame instead of a state machine.
    logic        e_w_en = 0, e_busy = 0, e_done = 0, e_err = 0;
    logic [7:0]  e_w_addr = 0;
    logic [15:0] e_w_data = 0;
    int          m_fr[$];
    int          m_n = 0, m_idle = 0;
    logic        m_in = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_w_en = 0; e_busy = 0; e_done = 0; e_err = 0;
            e_w_addr = 0; e_w_data = 0; m_in = 0; m_idle = 0;
            m_fr.delete();
        end else begin
            e_w_en = 0;
            e_done = 0;
            if (bus.rx_valid) begin
                m_idle = 0;
                if (!m_in) begin
                    if (bus.rx_data == 8'hA5) begin
                        m_in = 1; e_err = 0; m_fr.delete();
                    end
                end else begin
                    int p;
                    m_fr.push_back(int'(bus.rx_data));
                    p = m_fr.size() - 1;
                    if (p == 1) m_n = (bus.rx_data == 0) ? 256 : int'(bus.rx_data);
                    else if (p >= 2 && p < 2 + m_n * BPW) begin
                        if ((p - 1) % BPW == 0) begin
                            int w;
                            w = 0;
                            for (int i = 0; i < BPW; i++) w = (w << 8) | m_fr[p - BPW + 1 + i];
                            e_w_en = 1;
                            e_w_addr = 8'((m_fr[0] + (p - 2) / BPW) % MEM_DEPTH);
                            e_w_data = 16'(w);
                        end
                    end else if (p == 2 + m_n * BPW) begin
                        int s;
                        s = 0;
                        for (int i = 2; i < p; i++) s = s + m_fr[i];
                        e_err = (s % 256) != int'(bus.rx_data);
                        e_done = 1;
                        m_in = 0;
                    end
                end
            end else if (m_in) begin
                m_idle++;
                if (m_idle == TMO) begin
                    e_err = 1; e_done = 1; m_in = 0;
                end
            end
            e_busy = m_in;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [23:0] wr_log[$];
    logic        done_log[$];

    always @(negedge clk) begin
        chk("w_en", 32'(bus.w_en), 32'(e_w_en));
        chk("w_addr", 32'(bus.w_addr), 32'(e_w_addr));
        chk("w_data", 32'(bus.w_data), 32'(e_w_data));
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("cpu_hold", 32'(bus.cpu_hold), 32'(e_busy));
        chk("done", 32'(bus.done), 32'(e_done));
        chk("err", 32'(bus.err), 32'(e_err));
        if (bus.w_en) wr_log.push_back({bus.w_addr, bus.w_data});
        if (bus.done) done_log.push_back(bus.err);
    end

    logic [7:0] fr[$];

    task automatic put(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_fr();
        foreach (fr[i]) put(fr[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        done_log.delete();
    endtask

    initial begin
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset busy", 32'(bus.busy), 0);
        chk("reset w_en", 32'(bus.w_en), 0);
        chk("reset done", 32'(bus.done), 0);
        chk("reset err", 32'(bus.err), 0);

        // Valid load
        clear_logs();
        fr = '{8'hA5, 8'h10, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
        send_fr();
        idle(3);
        chk("valid writes", wr_log.size(), 2);
        chk("valid wr0", 32'(wr_log[0]), 32'h10_1234);
        chk("valid wr1", 32'(wr_log[1]), 32'h11_ABCD);
        chk("valid done", done_log.size(), 1);
        chk("valid err", 32'(done_log[0]), 0);

        // Checksum error, err sticky until next sync
        clear_logs();
        fr = '{8'hA5, 8'h10, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBF};
        send_fr();
        idle(5);
        chk("csum writes", wr_log.size(), 2);
        chk("csum done", done_log.size(), 1);
        chk("csum err", 32'(done_log[0]), 1);
        chk("csum sticky", 32'(bus.err), 1);
        put(8'hA5);
        chk("err cleared", 32'(bus.err), 0);

        // Address wrap (sync already sent)
        clear_logs();
        fr = '{8'hFF, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h03};
        send_fr();
        idle(3);
        chk("wrap writes", wr_log.size(), 2);
        chk("wrap wr0", 32'(wr_log[0]), 32'hFF_0001);
        chk("wrap wr1", 32'(wr_log[1]), 32'h00_0002);
        chk("wrap err", 32'(done_log.size() == 1 && done_log[0] == 1'b0), 1);

        // Timeout with a partial word
        clear_logs();
        fr = '{8'hA5, 8'h20, 8'h01, 8'h55};
        send_fr();
        idle(TMO + 4);
        chk("tmo writes", wr_log.size(), 0);
        chk("tmo done", done_log.size(), 1);
        chk("tmo err", 32'(done_log[0]), 1);
        chk("tmo busy", 32'(bus.busy), 0);

        // Junk before a valid frame
        clear_logs();
        fr = '{8'h00, 8'hFF, 8'h5A};
        send_fr();
        idle(2);
        chk("junk writes", wr_log.size(), 0);
        chk("junk done", done_log.size(), 0);
        chk("junk err held", 32'(bus.err), 1);
        fr = '{8'hA5, 8'h10, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
        send_fr();
        idle(3);
        chk("junk frame wr1", 32'(wr_log.size() == 2 && wr_log[1] == 24'h11_ABCD), 1);
        chk("junk frame err", 32'(done_log.size() == 1 && done_log[0] == 1'b0), 1);

        // Reset mid-frame, applied between clock edges
        clear_logs();
        fr = '{8'hA5, 8'h10, 8'h02, 8'h12};
        send_fr();
        chk("pre-rst busy", 32'(bus.busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("async busy", 32'(bus.busy), 0);
        chk("async hold", 32'(bus.cpu_hold), 0);
        chk("async w_addr", 32'(bus.w_addr), 0);
        chk("async w_data", 32'(bus.w_data), 0);
        chk("async err", 32'(bus.err), 0);
        @(posedge clk); #1 rst = 1'b0;
        idle(2);
        chk("rst no write", wr_log.size(), 0);
        fr = '{8'hA5, 8'h10, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
        send_fr();
        idle(3);
        chk("post-rst wr0", 32'(wr_log.size() == 2 && wr_log[0] == 24'h10_1234), 1);
        chk("post-rst done", 32'(done_log.size() == 1 && done_log[0] == 1'b0), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
